// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
// Used by uart_tx_arbiter and uart_rr_select.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPrefix = 2'd1,
    StXfer   = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned burst_cnt_width(int unsigned max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_select.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping modulo N.
module uart_rr_select
  import uart_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = id_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     pos;
  logic [IdxW-1:0] sel;
  logic            found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      sel = IdxW'(pos);
      if (!found && req_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        idx_o        = sel;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART TX through a registered output stage.
// Define UART_TX_ARB_ID_PREFIX_EN to emit the granted source index as a byte ahead of each grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N-1:0]            s_axis_tvalid,
  input  logic [N-1:0]            s_axis_tlast,
  output logic [N-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [N-1:0]            grant,
  output logic                    busy
);

  localparam int unsigned IdxW = id_width(N);

  arb_state_e            state_q, state_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic [N-1:0]          pick_grant;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_valid;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  out_free;
  logic                  accept;
  logic                  release_grant;
  logic                  burst_hit;

  uart_rr_select #(
    .N(N)
  ) u_rr_select (
    .req_i   (s_axis_tvalid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Owner's stream, selected by the one-hot grant.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign out_free      = !valid_q || m_axis_tready;
  assign accept        = (state_q == StXfer) && out_free && sel_valid;
  assign release_grant = accept && (sel_last || burst_hit);

  if (MAX_BURST > 0) begin : g_burst
    localparam int unsigned CntW = burst_cnt_width(MAX_BURST);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (release_grant) begin
        cnt_d = '0;
      end else if (accept) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // The accept that brings the count to MAX_BURST ends the grant.
    assign burst_hit = (cnt_q == CntW'(MAX_BURST - 1));
  end else begin : g_no_burst
    assign burst_hit = 1'b0;
  end

`ifdef UART_TX_ARB_ID_PREFIX_EN
  if (DATA_WIDTH < IdxW) begin : g_width_check
    $error("DATA_WIDTH too narrow to carry the requester index");
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (accept) begin
      data_d  = sel_data;
      valid_d = 1'b1;
    end else if (m_axis_tready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
`ifdef UART_TX_ARB_ID_PREFIX_EN
          state_d = StPrefix;
`else
          state_d = StXfer;
`endif
        end
      end
`ifdef UART_TX_ARB_ID_PREFIX_EN
      StPrefix: begin
        if (out_free) begin
          data_d  = DATA_WIDTH'(idx_q);
          valid_d = 1'b1;
          state_d = StXfer;
        end
      end
`endif
      StXfer: begin
        if (release_grant) begin
          grant_d = '0;
          state_d = StIdle;
          ptr_d   = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + IdxW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign s_axis_tready = ((state_q == StXfer) && out_free) ? grant_q : '0;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign grant         = grant_q;
  assign busy          = (state_q != StIdle) || valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: instance 0 is unlimited-burst, instance 1 has MAX_BURST=2.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] s_tdata  [2];
  logic [3:0]  s_tvalid [2];
  logic [3:0]  s_tlast  [2];
  logic [3:0]  s_tready [2];
  logic [7:0]  m_tdata  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [3:0]  grant    [2];
  logic        busy     [2];

  logic [8:0]  src_q [2][4][$];
  logic [7:0]  exp_q [2][$];
  logic        rdy_q [2][$];

  int n_total = 0;
  int n_bad   = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    uart_tx_arbiter #(
      .N          (4),
      .DATA_WIDTH (8),
      .MAX_BURST  ((d == 0) ? 0 : 2)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata[d]),
      .s_axis_tvalid (s_tvalid[d]),
      .s_axis_tlast  (s_tlast[d]),
      .s_axis_tready (s_tready[d]),
      .m_axis_tdata  (m_tdata[d]),
      .m_axis_tvalid (m_tvalid[d]),
      .m_axis_tready (m_tready[d]),
      .grant         (grant[d]),
      .busy          (busy[d])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input int d, input int s, input logic [7:0] b, input logic last);
    src_q[d][s].push_back({last, b});
  endtask

  task automatic drain(input int d, input string tag);
    int k = 0;
    while (exp_q[d].size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(exp_q[d].size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Source models: present queue heads, pop on a handshake seen at the preceding negedge.
  initial begin
    logic [3:0] hs [2];
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = '0;
      s_tlast[d]  = '0;
      s_tdata[d]  = '0;
      m_tready[d] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) hs[d] = s_tvalid[d] & s_tready[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (hs[d][i] && src_q[d][i].size() > 0) void'(src_q[d][i].pop_front());
          if (src_q[d][i].size() > 0) begin
            s_tvalid[d][i]       = 1'b1;
            s_tlast[d][i]        = src_q[d][i][0][8];
            s_tdata[d][i*8 +: 8] = src_q[d][i][0][7:0];
          end else begin
            s_tvalid[d][i]       = 1'b0;
            s_tlast[d][i]        = 1'b0;
            s_tdata[d][i*8 +: 8] = 8'h00;
          end
        end
        m_tready[d] = (rdy_q[d].size() > 0) ? rdy_q[d].pop_front() : 1'b1;
      end
    end
  end

  // Output monitor: compare each delivered byte against the scoreboard, check stall hold.
  initial begin
    logic       hold_v [2];
    logic [7:0] hold_d [2];
    logic [7:0] exp_b;
    hold_v[0] = 1'b0;
    hold_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          hold_v[d] = 1'b0;
        end else begin
          if (hold_v[d]) begin
            check("hold_valid", 32'(m_tvalid[d]), 32'd1);
            check("hold_data", 32'(m_tdata[d]), 32'(hold_d[d]));
          end
          if (m_tvalid[d] && m_tready[d]) begin
            if (exp_q[d].size() == 0) begin
              check("extra_beat", 32'(exp_q[d].size()), 32'd1);
            end else begin
              exp_b = exp_q[d].pop_front();
              check("out_data", 32'(m_tdata[d]), 32'(exp_b));
            end
          end
          hold_v[d] = m_tvalid[d] && !m_tready[d];
          hold_d[d] = m_tdata[d];
        end
      end
    end
  end

  initial begin
    int         n_acc, acc0, v0, n_v, last_v, ng;
    logic [7:0] pat;
    logic [3:0] prev_g;
    logic [3:0] gq [$];
    logic [3:0] t2_ord [4];
    bit         pushed, found;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_grant", 32'(grant[d]), 32'd0);
      check("rst_mvalid", 32'(m_tvalid[d]), 32'd0);
      check("rst_mdata", 32'(m_tdata[d]), 32'd0);
      check("rst_sready", 32'(s_tready[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

`ifdef UART_TX_ARB_ID_PREFIX_EN
    push_beat(0, 3, 8'hAA, 1'b1);
    exp_q[0].push_back(8'h03);
    exp_q[0].push_back(8'hAA);
    drain(0, "pfx_drain");
    check("pfx_idle_grant", 32'(grant[0]), 32'd0);
`else
    // Single source 2, three beats.
    push_beat(0, 2, 8'h41, 1'b0);
    push_beat(0, 2, 8'h42, 1'b0);
    push_beat(0, 2, 8'h43, 1'b1);
    exp_q[0].push_back(8'h41);
    exp_q[0].push_back(8'h42);
    exp_q[0].push_back(8'h43);
    n_acc = 0; acc0 = -1; v0 = -1; n_v = 0; last_v = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (s_tvalid[0][2] && s_tready[0][2]) begin
        n_acc++;
        if (acc0 < 0) acc0 = k;
        check("t1_grant", 32'(grant[0]), 32'h4);
      end
      if (m_tvalid[0]) begin
        n_v++;
        if (v0 < 0) v0 = k;
        last_v = k;
      end
      if (k == 3) check("t1_busy", 32'(busy[0]), 32'd1);
    end
    check("t1_accepts", 32'(n_acc), 32'd3);
    check("t1_latency", 32'(v0 - acc0), 32'd1);
    check("t1_valid_cycles", 32'(n_v), 32'd3);
    check("t1_contiguous", 32'(last_v - v0), 32'd2);
    check("t1_grant_end", 32'(grant[0]), 32'd0);
    check("t1_busy_end", 32'(busy[0]), 32'd0);
    drain(0, "t1_drain");

    // Round robin across sources 0, 1, 3 with source 0 starting first.
    push_beat(0, 0, 8'h10, 1'b0);
    push_beat(0, 0, 8'h11, 1'b1);
    push_beat(0, 0, 8'h12, 1'b0);
    push_beat(0, 0, 8'h13, 1'b1);
    exp_q[0] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h12, 8'h13};
    t2_ord = '{4'h1, 4'h2, 4'h8, 4'h1};
    gq.delete();
    prev_g = 4'h0;
    pushed = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (grant[0] != 4'h0 && prev_g == 4'h0) gq.push_back(grant[0]);
      if (!pushed && grant[0] == 4'h1) begin
        push_beat(0, 1, 8'h20, 1'b0);
        push_beat(0, 1, 8'h21, 1'b1);
        push_beat(0, 3, 8'h30, 1'b0);
        push_beat(0, 3, 8'h31, 1'b1);
        pushed = 1'b1;
      end
      prev_g = grant[0];
    end
    check("t2_grant_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_grant_order", (i < gq.size()) ? 32'(gq[i]) : 32'd0, 32'(t2_ord[i]));
    end
    drain(0, "t2_drain");

    // Backpressure on a 4-beat packet from source 1.
    push_beat(0, 1, 8'h51, 1'b0);
    push_beat(0, 1, 8'h52, 1'b0);
    push_beat(0, 1, 8'h53, 1'b0);
    push_beat(0, 1, 8'h54, 1'b1);
    exp_q[0] = '{8'h51, 8'h52, 8'h53, 8'h54};
    rdy_q[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    pat = 8'h00;
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant[0] == 4'h2) begin
        pat = {pat[6:0], s_tready[0][1]};
        ng++;
      end
    end
    check("t3_grant_cycles", 32'(ng), 32'd6);
    check("t3_ready_pattern", 32'(pat[5:0]), 32'h33);
    drain(0, "t3_drain");

    // Burst limit on instance 1: source 0 long packet, source 1 waiting.
    push_beat(1, 0, 8'h60, 1'b0);
    push_beat(1, 0, 8'h61, 1'b0);
    push_beat(1, 0, 8'h62, 1'b0);
    push_beat(1, 0, 8'h63, 1'b0);
    push_beat(1, 0, 8'h64, 1'b1);
    push_beat(1, 1, 8'h70, 1'b0);
    push_beat(1, 1, 8'h71, 1'b1);
    exp_q[1] = '{8'h60, 8'h61, 8'h70, 8'h71, 8'h62, 8'h63, 8'h64};
    drain(1, "t4_drain");
    check("t4_grant_end", 32'(grant[1]), 32'd0);

    // Reset mid-packet while source 1 owns the output.
    push_beat(0, 1, 8'hC1, 1'b0);
    push_beat(0, 1, 8'hC2, 1'b0);
    push_beat(0, 1, 8'hC3, 1'b0);
    push_beat(0, 1, 8'hC4, 1'b1);
    exp_q[0] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_tvalid[0] && grant[0] == 4'h2) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_midpacket", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_mvalid", 32'(m_tvalid[0]), 32'd0);
    check("t5_async_grant", 32'(grant[0]), 32'd0);
    check("t5_async_busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 4; i++) src_q[0][i].delete();
    exp_q[0].delete();
    rdy_q[0].delete();
    repeat (2) @(negedge clk);
    push_beat(0, 0, 8'h80, 1'b1);
    push_beat(0, 3, 8'h90, 1'b1);
    exp_q[0] = '{8'h80, 8'h90};
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant[0] != 4'h0) break;
    end
    check("t5_first_grant", 32'(grant[0]), 32'h1);
    drain(0, "t5_drain");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
